pipe_skid_reg: RTL and testbench

//   Elastic pipeline stage: consumer-side counterpart of the plain always-load register.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_reg_en_reg.sv | 43 ++++
 rtl/pipe_skid_reg.sv | 147 ++++++++++++++
 tb/tb_pipe_skid_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the elastic pipeline stage.
//   - State encodings for the skid-buffer controller (EMPTY/BUSY/FULL).
//   - Default payload width.
//   - count_of(): occupancy decode of a state value (illegal encoding -> 0).
package pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  // Occupancy implied by a state; the unused encoding reports empty.
  function automatic logic [1:0] count_of(input logic [1:0] st);
    logic [1:0] c;
    case (st)
      ST_EMPTY: c = 2'd0;
      ST_BUSY:  c = 2'd1;
      ST_FULL:  c = 2'd2;
      default:  c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_en_reg.sv
// en_reg: load-enable data register with asynchronous active-low clear.
//   clk    in   rising-edge clock
//   rst_n  in   async active-low clear (contents -> 0)
//   en     in   load d at the next edge when high, otherwise hold
//   d      in   WIDTH  next value
//   q      out  WIDTH  registered value
module en_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Next value: load when enabled, otherwise recirculate.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flop, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline stage with a 2-entry skid buffer.
//   1-cycle latency, full throughput; in_ready depends only on the state
//   register so downstream stalls never form a combinational ready path.
//   clk        in   rising-edge clock
//   rst_n      in   async active-low reset
//   flush      in   synchronous discard of all held entries (wins over transfers)
//   in_valid   in   upstream data present
//   in_data    in   WIDTH upstream payload
//   in_ready   out  stage can accept (low only when FULL)
//   out_valid  out  out_data holds a valid head entry
//   out_data   out  WIDTH head payload (registered)
//   out_ready  in   downstream accepts this cycle
//   count      out  2 occupancy 0..2
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [1:0]       state_d;
  logic [1:0]       state_q;
  logic             load_out_s;
  logic             load_skid_s;
  logic             out_sel_skid_s;
  logic [WIDTH-1:0] out_nxt_s;
  logic [WIDTH-1:0] skid_data_s;

  // Next-state and data-path enables. in_valid is ignored when FULL because
  // in_ready is low there; flush suppresses every load and empties the stage.
  always_comb begin
    state_d        = state_q;
    load_out_s     = 1'b0;
    load_skid_s    = 1'b0;
    out_sel_skid_s = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            load_out_s = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            state_d    = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (in_valid && out_ready) begin
            load_out_s  = 1'b1;
            state_d     = ST_BUSY;
          end else if (in_valid) begin
            // Head is stalled: park the new beat behind it.
            load_skid_s = 1'b1;
            state_d     = ST_FULL;
          end else if (out_ready) begin
            state_d     = ST_EMPTY;
          end else begin
            state_d     = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            // Head leaves; the skid entry is promoted, preserving order.
            load_out_s     = 1'b1;
            out_sel_skid_s = 1'b1;
            state_d        = ST_BUSY;
          end else begin
            state_d        = ST_FULL;
          end
        end
        default: begin
          // Unused encoding: recover to EMPTY without moving data.
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Head register source: new input beat, or promoted skid entry.
  always_comb begin
    if (out_sel_skid_s) begin
      out_nxt_s = skid_data_s;
    end else begin
      out_nxt_s = in_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    case (state_q)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ST_BUSY: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
    count = count_of(state_q);
  end

  en_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_out_s),
    .d     (out_nxt_s),
    .q     (out_data)
  );

  en_reg #(.WIDTH(WIDTH)) u_skid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_skid_s),
    .d     (in_data),
    .q     (skid_data_s)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and randomized self-checking bench for pipe_skid_reg.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  count;

  int n_cmp;
  int n_err;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir,
                           input logic [1:0] cnt);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    chk({tag, ".count"},     {30'd0, count},     {30'd0, cnt});
  endtask

  logic [31:0] sb[$];
  logic [31:0] exp_v;
  logic        acc_in;
  logic        acc_out;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;

    // 1. Reset with random inputs toggling.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk_state("rst", 1'b0, 1'b1, 2'd0);
    chk("rst.out_data", out_data, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3 rst_n = 1'b1;
    step();

    // 2. Streaming 1..10 with out_ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      chk("stream.data", out_data, 32'(i));
      chk_state("stream", 1'b1, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    step();
    chk_state("stream.drain", 1'b0, 1'b1, 2'd0);

    // 3. Backpressure: A, B, C with out_ready low from the cycle after A.
    in_valid = 1'b1; in_data = 32'h0000_000A;
    step();
    chk("bp.headA", out_data, 32'h0000_000A);
    out_ready = 1'b0; in_data = 32'h0000_000B;
    step();
    chk_state("bp.full", 1'b1, 1'b0, 2'd2);
    in_data = 32'h0000_000C;
    step();
    chk_state("bp.hold", 1'b1, 1'b0, 2'd2);
    chk("bp.holdA", out_data, 32'h0000_000A);
    out_ready = 1'b1;
    step();
    chk("bp.B", out_data, 32'h0000_000B);
    chk_state("bp.busyB", 1'b1, 1'b1, 2'd1);
    step();
    chk("bp.C", out_data, 32'h0000_000C);
    in_valid = 1'b0;
    step();
    chk_state("bp.empty", 1'b0, 1'b1, 2'd0);

    // 4. Flush while FULL, with D offered in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_00A1;
    step();
    in_data = 32'h0000_00B1;
    step();
    chk_state("fl.pre", 1'b1, 1'b0, 2'd2);
    flush = 1'b1; in_data = 32'h0000_00D1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk_state("fl.post", 1'b0, 1'b1, 2'd0);
    out_ready = 1'b1;
    step();
    chk_state("fl.noD", 1'b0, 1'b1, 2'd0);

    // 5. Asynchronous reset in the middle of a FULL cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0E01;
    step();
    in_data = 32'h0000_0E02;
    step();
    in_valid = 1'b0;
    chk_state("ar.pre", 1'b1, 1'b0, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_state("ar.now", 1'b0, 1'b1, 2'd0);
    chk("ar.out_data", out_data, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk_state("ar.after", 1'b0, 1'b1, 2'd0);

    // 6. Random valid/ready against a scoreboard queue.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    acc_in    = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      chk("rnd.count", {30'd0, count}, 32'(sb.size()));
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, (sb.size() != 2)});
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
      // A beat offered but not taken must stay put.
      if (!(in_valid && !acc_in)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc_in  = in_valid && (sb.size() != 2);
      acc_out = out_ready && (sb.size() != 0);
      if (acc_out) begin
        exp_v = sb.pop_front();
        chk("rnd.data", out_data, exp_v);
      end
      if (acc_in) begin
        sb.push_back(in_data);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
